// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fetch/data arbiter onto one unified memory port
//
// Ports:
//   clk, rstn                         clock, async active-low reset
//   iReq, iAddr -> iRdata, iValid     fetch requester (level request, 1-cycle valid)
//   dReq, dWe, dAddr, dWdata, dMask   load/store requester
//     -> dRdata, dValid
//   err                               qualifies iValid/dValid as a timeout abort
//   mReq, mWe, mAddr, mWdata, mMask   memory request (held until mAck or timeout)
//   mRdata, mAck                      memory response (data valid in the mAck cycle)
module mem_arbiter #(
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic [31:0] iRdata,
  output logic        iValid,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [3:0]  dMask,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        err,
  output logic        mReq,
  output logic        mWe,
  output logic [31:0] mAddr,
  output logic [31:0] mWdata,
  output logic [3:0]  mMask,
  input  logic [31:0] mRdata,
  input  logic        mAck
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_n;
  logic          last_d, last_d_n;   // 1 = data held the previous grant
  logic [CW-1:0] cnt, cnt_n;

  logic          mreq_n, mwe_n, ivalid_n, dvalid_n, err_n;
  logic [31:0]   maddr_n, mwdata_n, irdata_n, drdata_n;
  logic [3:0]    mmask_n;

  logic          grant_d;
  logic          timeout_hit;

  // Data wins a tie under fixed priority; under round-robin it wins only
  // when fetch held the previous grant.
  assign grant_d     = dReq && (!iReq || (DATA_PRIORITY != 0) || !last_d);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      last_d <= 1'b1;
      cnt    <= '0;
      mReq   <= 1'b0;
      mWe    <= 1'b0;
      mAddr  <= '0;
      mWdata <= '0;
      mMask  <= '0;
      iValid <= 1'b0;
      iRdata <= '0;
      dValid <= 1'b0;
      dRdata <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
      cnt    <= cnt_n;
      mReq   <= mreq_n;
      mWe    <= mwe_n;
      mAddr  <= maddr_n;
      mWdata <= mwdata_n;
      mMask  <= mmask_n;
      iValid <= ivalid_n;
      iRdata <= irdata_n;
      dValid <= dvalid_n;
      dRdata <= drdata_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    last_d_n = last_d;
    cnt_n    = cnt;
    mreq_n   = mReq;
    mwe_n    = mWe;
    maddr_n  = mAddr;
    mwdata_n = mWdata;
    mmask_n  = mMask;
    irdata_n = iRdata;
    drdata_n = dRdata;
    ivalid_n = 1'b0;
    dvalid_n = 1'b0;
    err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_n  = BUSY_D;
          mreq_n   = 1'b1;
          mwe_n    = dWe;
          maddr_n  = dAddr;
          mwdata_n = dWdata;
          mmask_n  = dMask;
          last_d_n = 1'b1;
          cnt_n    = '0;
        end else if (iReq) begin
          state_n  = BUSY_I;
          mreq_n   = 1'b1;
          mwe_n    = 1'b0;
          maddr_n  = iAddr;
          mwdata_n = '0;
          mmask_n  = 4'hF;
          last_d_n = 1'b0;
          cnt_n    = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        // mAck is checked first so an ack in the expiry cycle completes normally.
        if (mAck) begin
          state_n = IDLE;
          mreq_n  = 1'b0;
          mwe_n   = 1'b0;
          if (state == BUSY_D) begin
            dvalid_n = 1'b1;
            drdata_n = mRdata;
          end else begin
            ivalid_n = 1'b1;
            irdata_n = mRdata;
          end
        end else if (timeout_hit) begin
          state_n = IDLE;
          mreq_n  = 1'b0;
          err_n   = 1'b1;
          if (state == BUSY_D) begin
            dvalid_n = 1'b1;
            drdata_n = '0;
          end else begin
            ivalid_n = 1'b1;
            irdata_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
